// File: rtl/rop_pkg.sv
// Shared definitions for the ROP logical-op read-modify-write path:
// opcode encodings, channel count and the per-entry control record.
package rop_pkg;

    localparam int ROP_NCH = 4;

    localparam logic [3:0] ROP_CLEAR   = 4'h0;  // 0
    localparam logic [3:0] ROP_AND     = 4'h1;  // s & d
    localparam logic [3:0] ROP_OR      = 4'h2;  // s | d
    localparam logic [3:0] ROP_XOR     = 4'h3;  // s ^ d
    localparam logic [3:0] ROP_NAND    = 4'h4;  // ~(s & d)
    localparam logic [3:0] ROP_NOR     = 4'h5;  // ~(s | d)
    localparam logic [3:0] ROP_EQUIV   = 4'h6;  // ~(s ^ d)
    localparam logic [3:0] ROP_INVERT  = 4'h7;  // ~d
    localparam logic [3:0] ROP_COPY    = 4'h8;  // s
    localparam logic [3:0] ROP_NOOP    = 4'h9;  // d
    localparam logic [3:0] ROP_AND_INV = 4'hA;  // s & ~d
    localparam logic [3:0] ROP_INV_AND = 4'hB;  // ~s & d
    localparam logic [3:0] ROP_SRC_CLR = 4'hC;  // s & ~(s & d)
    localparam logic [3:0] ROP_OR_INV  = 4'hD;  // s | ~d
    localparam logic [3:0] ROP_INV_OR  = 4'hE;  // ~s | d
    localparam logic [3:0] ROP_SET     = 4'hF;  // all ones

    // Control part of an in-flight entry; wide fields live in side arrays
    // because their widths are parameters of the owning module.
    typedef struct packed {
        logic       vld;
        logic       dvld;
        logic [3:0] opcode;
        logic [3:0] mask;
    } rop_ent_ctl_t;

endpackage

// File: rtl/rop_logic_func.sv
// Combinational 16-function logical op with per-channel write mask.
// Unmasked channels pass the destination colour through unchanged.
module rop_logic_func
    import rop_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_src,
    input  logic [WIDTH-1:0] i_dest,
    input  logic [3:0]       i_opcode,
    input  logic [3:0]       i_mask,
    output logic [WIDTH-1:0] o_result
);

    localparam int CW = WIDTH / ROP_NCH;

    logic [WIDTH-1:0] w_f;

    // Full-word logical function selected by opcode
    always_comb begin
        w_f = '0;
        case (i_opcode)
            ROP_CLEAR:   w_f = '0;
            ROP_AND:     w_f = i_src & i_dest;
            ROP_OR:      w_f = i_src | i_dest;
            ROP_XOR:     w_f = i_src ^ i_dest;
            ROP_NAND:    w_f = ~(i_src & i_dest);
            ROP_NOR:     w_f = ~(i_src | i_dest);
            ROP_EQUIV:   w_f = ~(i_src ^ i_dest);
            ROP_INVERT:  w_f = ~i_dest;
            ROP_COPY:    w_f = i_src;
            ROP_NOOP:    w_f = i_dest;
            ROP_AND_INV: w_f = i_src & ~i_dest;
            ROP_INV_AND: w_f = ~i_src & i_dest;
            ROP_SRC_CLR: w_f = i_src & ~(i_src & i_dest);
            ROP_OR_INV:  w_f = i_src | ~i_dest;
            ROP_INV_OR:  w_f = ~i_src | i_dest;
            ROP_SET:     w_f = '1;
            default:     w_f = '0;
        endcase
    end

    for (genvar c = 0; c < ROP_NCH; c++) begin : g_ch
        assign o_result[c*CW +: CW] = i_mask[c] ? w_f[c*CW +: CW] : i_dest[c*CW +: CW];
    end

endmodule

// File: rtl/rop_logic_rmw_ctrl.sv
// Read-modify-write sequencer for the ROP logical-op path.
// Fragments are accepted together with their cache read, held in a circular
// buffer until the destination returns, then written back in order. Any
// fragment whose address matches a live entry is stalled to keep per-pixel
// RAW order.
// Optional macro ROP_RMW_PERF_EN adds saturating accept / hazard counters.
module rop_logic_rmw_ctrl
    import rop_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 20,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frag_valid,
    output logic              frag_ready,
    input  logic [ADDR_W-1:0] frag_addr,
    input  logic [WIDTH-1:0]  frag_src,
    input  logic [3:0]        frag_opcode,
    input  logic [3:0]        frag_mask,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_rsp_valid,
    input  logic [WIDTH-1:0]  rd_rsp_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    output logic              busy
`ifdef ROP_RMW_PERF_EN
    ,
    output logic [31:0]       perf_frag_cnt,
    output logic [31:0]       perf_hazard_cnt
`endif
);

    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW:0]     CNT_FULL = (PW+1)'(DEPTH);

    rop_ent_ctl_t      r_ent  [DEPTH];
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [WIDTH-1:0]  r_src  [DEPTH];
    logic [WIDTH-1:0]  r_dest [DEPTH];

    logic [PW-1:0] r_alloc;
    logic [PW-1:0] r_rsp;
    logic [PW-1:0] r_retire;
    logic [PW:0]   r_count;

    logic w_hazard;
    logic w_any_vld;
    logic w_full;
    logic w_accept;
    logic w_rsp_hit;
    logic w_rsp_ok;
    logic w_wr_valid;
    logic w_retire;

    // Address match against every live entry, including one retiring now
    always_comb begin
        w_hazard  = 1'b0;
        w_any_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_ent[i].vld) begin
                w_any_vld = 1'b1;
                if (r_addr[i] == frag_addr) w_hazard = 1'b1;
            end
        end
    end

    assign w_full       = (r_count == CNT_FULL);
    assign rd_req_valid = frag_valid   & ~w_hazard & ~w_full & ~rst;
    assign frag_ready   = rd_req_ready & ~w_hazard & ~w_full & ~rst;
    assign rd_req_addr  = frag_addr;
    assign w_accept     = frag_valid & frag_ready;

    // A response only counts when the oldest waiting entry has its read out
    assign w_rsp_hit    = r_ent[r_rsp].vld & ~r_ent[r_rsp].dvld;
    assign w_rsp_ok     = rd_rsp_valid & w_rsp_hit & ~rst;

    assign w_wr_valid   = r_ent[r_retire].vld & r_ent[r_retire].dvld & ~rst;
    assign w_retire     = w_wr_valid & wr_ready;
    assign wr_valid     = w_wr_valid;
    assign wr_addr      = r_addr[r_retire];
    assign busy         = w_any_vld & ~rst;

    rop_logic_func #(.WIDTH(WIDTH)) u_func (
        .i_src    (r_src[r_retire]),
        .i_dest   (r_dest[r_retire]),
        .i_opcode (r_ent[r_retire].opcode),
        .i_mask   (r_ent[r_retire].mask),
        .o_result (wr_data)
    );

    // Entry buffer: allocate, fill destination, retire; all may coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i].vld  <= 1'b0;
                r_ent[i].dvld <= 1'b0;
            end
            r_alloc  <= '0;
            r_rsp    <= '0;
            r_retire <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_ent[r_alloc].vld    <= 1'b1;
                r_ent[r_alloc].dvld   <= 1'b0;
                r_ent[r_alloc].opcode <= frag_opcode;
                r_ent[r_alloc].mask   <= frag_mask;
                r_addr[r_alloc]       <= frag_addr;
                r_src[r_alloc]        <= frag_src;
                r_alloc               <= r_alloc + 1'b1;
            end
            if (w_rsp_ok) begin
                r_ent[r_rsp].dvld <= 1'b1;
                r_dest[r_rsp]     <= rd_rsp_data;
                r_rsp             <= r_rsp + 1'b1;
            end
            if (w_retire) begin
                r_ent[r_retire].vld  <= 1'b0;
                r_ent[r_retire].dvld <= 1'b0;
                r_retire             <= r_retire + 1'b1;
            end
            case ({w_accept, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Flag a read response that arrives with no read outstanding
    always_ff @(posedge clk) begin
        if (!rst && rd_rsp_valid) assert (w_rsp_hit);
    end

`ifdef ROP_RMW_PERF_EN
    logic [31:0] r_perf_frag;
    logic [31:0] r_perf_hazard;

    // Saturating counts of accepted fragments and hazard-stalled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_frag   <= '0;
            r_perf_hazard <= '0;
        end else begin
            if (w_accept && r_perf_frag != '1)
                r_perf_frag <= r_perf_frag + 1'b1;
            if (frag_valid && w_hazard && r_perf_hazard != '1)
                r_perf_hazard <= r_perf_hazard + 1'b1;
        end
    end

    assign perf_frag_cnt   = r_perf_frag;
    assign perf_hazard_cnt = r_perf_hazard;
`endif

endmodule

// File: tb/tb_rop_logic_rmw_ctrl.sv
// Scoreboard bench for rop_logic_rmw_ctrl: a golden per-address colour
// memory predicts each write at fragment acceptance; a monitor pops and
// compares on every write handshake. A behavioural cache answers reads.
module tb_rop_logic_rmw_ctrl;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 20;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frag_valid = 1'b0;
    logic              frag_ready;
    logic [ADDR_W-1:0] frag_addr = '0;
    logic [WIDTH-1:0]  frag_src = '0;
    logic [3:0]        frag_opcode = '0;
    logic [3:0]        frag_mask = '0;
    logic              rd_req_valid;
    logic              rd_req_ready = 1'b1;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_rsp_valid = 1'b0;
    logic [WIDTH-1:0]  rd_rsp_data = '0;
    logic              wr_valid;
    logic              wr_ready = 1'b1;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              busy;
`ifdef ROP_RMW_PERF_EN
    logic [31:0]       perf_frag_cnt;
    logic [31:0]       perf_hazard_cnt;
`endif

    rop_logic_rmw_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .frag_valid   (frag_valid),
        .frag_ready   (frag_ready),
        .frag_addr    (frag_addr),
        .frag_src     (frag_src),
        .frag_opcode  (frag_opcode),
        .frag_mask    (frag_mask),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data  (rd_rsp_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy)
`ifdef ROP_RMW_PERF_EN
        ,
        .perf_frag_cnt   (perf_frag_cnt),
        .perf_hazard_cnt (perf_hazard_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [WIDTH-1:0]  d;
    } exp_t;

    exp_t              expq[$];
    logic [ADDR_W-1:0] pend[$];
    logic [WIDTH-1:0]  cache [64];
    logic [WIDTH-1:0]  gold  [64];

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int acc_cnt = 0;
    int rsp_pct = 100;
    int wr_pct  = 100;
    int rrq_pct = 100;
    bit rsp_en  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: per 8-bit channel, apply the named logical function, keep dest where masked off
    function automatic logic [31:0] model(input logic [31:0] s, input logic [31:0] d,
                                          input logic [3:0] op, input logic [3:0] m);
        logic [31:0] r;
        logic [7:0]  sc, dc, f;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            sc = s[c*8 +: 8];
            dc = d[c*8 +: 8];
            case (op)
                4'h0: f = 8'h00;
                4'h1: f = sc & dc;
                4'h2: f = sc | dc;
                4'h3: f = sc ^ dc;
                4'h4: f = ~(sc & dc);
                4'h5: f = ~(sc | dc);
                4'h6: f = ~(sc ^ dc);
                4'h7: f = ~dc;
                4'h8: f = sc;
                4'h9: f = dc;
                4'hA: f = sc & ~dc;
                4'hB: f = ~sc & dc;
                4'hC: f = sc & ~(sc & dc);
                4'hD: f = sc | ~dc;
                4'hE: f = ~sc | dc;
                default: f = 8'hFF;
            endcase
            r[c*8 +: 8] = m[c] ? f : dc;
        end
        return r;
    endfunction

    // Behavioural cache: answers reads in order after a random delay
    initial begin
        logic [ADDR_W-1:0] a;
        forever begin
            @(posedge clk); #1;
            if (rsp_en && !rst && pend.size() > 0 && int'($urandom_range(99)) < rsp_pct) begin
                a = pend.pop_front();
                rd_rsp_valid = 1'b1;
                rd_rsp_data  = cache[a[5:0]];
            end else begin
                rd_rsp_valid = 1'b0;
                rd_rsp_data  = '0;
            end
        end
    end

    // Random ready generation for the cache read and write ports
    initial begin
        forever begin
            @(posedge clk); #1;
            wr_ready     = int'($urandom_range(99)) < wr_pct;
            rd_req_ready = int'($urandom_range(99)) < rrq_pct;
        end
    end

    // Monitor: sampled mid-cycle, the values the next rising edge will act on
    initial begin
        exp_t              e;
        logic              prev_stall = 1'b0;
        logic [ADDR_W-1:0] st_a = '0;
        logic [WIDTH-1:0]  st_d = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("wr_hold_valid", 64'(wr_valid), 64'(1));
                    chk("wr_hold_addr",  64'(wr_addr),  64'(st_a));
                    chk("wr_hold_data",  64'(wr_data),  64'(st_d));
                end
                if (rd_req_valid && rd_req_ready) begin
                    chk("rd_req_addr", 64'(rd_req_addr), 64'(frag_addr));
                    pend.push_back(rd_req_addr);
                end
                if (wr_valid && wr_ready) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wr_unexpected: got addr %0h with no write expected", wr_addr);
                    end else begin
                        e = expq.pop_front();
                        chk("wr_addr", 64'(wr_addr), 64'(e.a));
                        chk("wr_data", 64'(wr_data), 64'(e.d));
                    end
                    cache[wr_addr[5:0]] = wr_data;
                    wr_cnt++;
                end
                prev_stall = wr_valid && !wr_ready;
                st_a = wr_addr;
                st_d = wr_data;
            end
        end
    end

    // Offer one fragment; called and returns just after a rising edge
    task automatic send(input logic [ADDR_W-1:0] a, input logic [31:0] s,
                        input logic [3:0] op, input logic [3:0] m);
        bit   done = 1'b0;
        exp_t e;
        frag_valid = 1'b1; frag_addr = a; frag_src = s; frag_opcode = op; frag_mask = m;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (frag_ready) begin
                done = 1'b1;
                e.a = a;
                e.d = model(s, gold[a[5:0]], op, m);
                gold[a[5:0]] = e.d;
                expq.push_back(e);
                acc_cnt++;
            end
            @(posedge clk); #1;
        end
        frag_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: addr %0h not accepted, required acceptance", a);
        end
    endtask

    task automatic wait_wr(input string nm, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        bit found = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            @(negedge clk);
            if (wr_valid && wr_ready) begin
                found = 1'b1;
                chk(nm, 64'({wr_addr, wr_data}), 64'({a, d}));
            end
            @(posedge clk); #1;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no write seen, required addr %0h", nm, a);
        end
    endtask

    task automatic drain(input string nm);
        for (int t = 0; t < 3000 && (expq.size() > 0 || busy); t++) begin
            @(posedge clk); #1;
        end
        chk(nm, 64'(expq.size()), 64'(0));
    endtask

    task automatic hold_blocked(input string nm);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(nm, 64'({frag_ready, rd_req_valid}), 64'(0));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 64; i++) begin
            cache[i] = $urandom;
            gold[i]  = cache[i];
        end

        // Reset state
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_outputs", 64'({busy, wr_valid, frag_ready, rd_req_valid}), 64'(0));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst", 64'({busy, wr_valid, frag_ready}), 64'(3'b001));
`ifdef ROP_RMW_PERF_EN
        chk("perf_rst", 64'({perf_frag_cnt, perf_hazard_cnt}), 64'(0));
`endif
        @(posedge clk); #1;

        // Single XOR fragment with minimum latency
        cache[16] = 32'hFFFF_FFFF; gold[16] = 32'hFFFF_FFFF;
        rsp_en = 1'b1;
        send(20'h10, 32'h1234_5678, 4'h3, 4'hF);
        @(negedge clk);
        chk("lat_early", 64'(wr_valid), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("xor_wr", 64'({wr_valid, wr_addr, wr_data}), {11'd0, 1'b1, 20'h10, 32'hEDCB_A987});
        @(posedge clk); #1;

        // Channel mask
        cache[17] = 32'hAABB_CCDD; gold[17] = 32'hAABB_CCDD;
        send(20'h11, $urandom, 4'hF, 4'h5);
        wait_wr("mask_wr", 20'h11, 32'hAAFF_CCFF);

        // Mask 0 still writes dest
        send(20'h12, $urandom, 4'h3, 4'h0);
        wait_wr("mask0_wr", 20'h12, cache[18]);

        // Hazard on same address
        rsp_en = 1'b0;
        send(20'h20, $urandom, 4'h2, 4'hF);
        w0 = wr_cnt;
        frag_valid = 1'b1; frag_addr = 20'h20;
        hold_blocked("hazard_block");
        rsp_en = 1'b1;
        send(20'h20, $urandom, 4'h1, 4'hF);
        chk("hazard_after_wr", 64'(wr_cnt > w0), 64'(1));
        drain("hazard_drain");

        // Full buffer
        rsp_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(20'(32 + 16 + i), $urandom, 4'(i), 4'hF);
        w0 = wr_cnt;
        frag_valid = 1'b1; frag_addr = 20'h3F;
        hold_blocked("full_block");
        @(negedge clk);
        chk("full_busy", 64'(busy), 64'(1));
        @(posedge clk); #1;
        rsp_en = 1'b1;
        send(20'h3F, $urandom, 4'h6, 4'hA);
        chk("full_after_wr", 64'(wr_cnt > w0), 64'(1));
        drain("full_drain");

        // Write backpressure with three data-valid entries
        rsp_en = 1'b0; wr_pct = 0;
        for (int i = 0; i < 3; i++) send(20'(40 + i), $urandom, 4'hC, 4'hF);
        rsp_en = 1'b1;
        repeat (9) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("bp_stalled", 64'({wr_valid, 2'(expq.size())}), 64'(3'b111));
        @(posedge clk); #1;
        wr_pct = 100;
        begin
            bit seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                if (wr_valid && wr_ready) seen = 1'b1;
                @(posedge clk); #1;
            end
            chk("bp_first", 64'(seen), 64'(1));
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                chk("bp_burst", 64'(wr_valid && wr_ready), 64'(1));
                @(posedge clk); #1;
            end
        end
        drain("bp_drain");

        // Reset with three entries in flight
        rsp_en = 1'b0;
        for (int i = 0; i < 3; i++) send(20'(56 + i), $urandom, 4'h7, 4'hF);
        rst = 1'b1;
        pend.delete(); expq.delete();
        @(negedge clk);
        chk("midrst_during", 64'({busy, wr_valid, frag_ready, rd_req_valid}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        acc_cnt = 0;
        @(negedge clk);
        chk("midrst_after", 64'({busy, wr_valid, frag_ready}), 64'(3'b001));
`ifdef ROP_RMW_PERF_EN
        chk("perf_midrst", 64'({perf_frag_cnt, perf_hazard_cnt}), 64'(0));
`endif
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) gold[i] = cache[i];
        rsp_en = 1'b1;

        // Randomized traffic on a small address set to force hazards
        rsp_pct = 60; wr_pct = 70; rrq_pct = 80;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(2)) begin @(posedge clk); #1; end
            send(20'($urandom_range(15)), $urandom, 4'($urandom), 4'($urandom));
        end
        rsp_pct = 100; wr_pct = 100; rrq_pct = 100;
        drain("rand_drain");
        @(negedge clk);
        chk("final_idle", 64'({busy, wr_valid}), 64'(0));
`ifdef ROP_RMW_PERF_EN
        chk("perf_frag", 64'(perf_frag_cnt), 64'(acc_cnt));
`endif
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
